// File: rtl/fft_cmul_pkg.sv
// Shared constants and types for the FFT complex-multiply combine stage.
// Optional build macro CMUL_SCALE_EN is consumed by fft_cmul_combine.
package fft_cmul_pkg;

    localparam int MAG_W_DEF = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Arrival order of the four partial products of one twiddle multiply
    localparam logic [1:0] IDX_RR = 2'd0;
    localparam logic [1:0] IDX_II = 2'd1;
    localparam logic [1:0] IDX_RI = 2'd2;
    localparam logic [1:0] IDX_IR = 3'd3;

endpackage

// File: rtl/fft_cmul_combine_sm_to_tc.sv
// Combinational sign-magnitude to two's-complement converter.
// Negative zero naturally maps to zero because -0 == 0.
module sm_to_tc
    import fft_cmul_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF,
    parameter int OUT_W = MAG_W + 2
) (
    input  logic [MAG_W:0]          prd,
    output logic signed [OUT_W-1:0] tc
);

    logic signed [OUT_W-1:0] mag_ext;

    assign mag_ext = $signed({{(OUT_W-MAG_W){1'b0}}, prd[MAG_W-1:0]});
    assign tc      = prd[MAG_W] ? -mag_ext : mag_ext;

endmodule

// File: rtl/fft_cmul_combine.sv
// Collects four sign-magnitude partial products and emits re = p0 - p1, im = p2 + p3.
// Define CMUL_SCALE_EN to halve the outputs with round-half-up.
module fft_cmul_combine
    import fft_cmul_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF,
    parameter int OUT_W = MAG_W + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [MAG_W:0]          prd_in,
    input  logic                    prd_rdy,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] re_out,
    output logic signed [OUT_W-1:0] im_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    drop_err
);

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic signed [OUT_W-1:0] acc_re_q, acc_re_d;
    logic signed [OUT_W-1:0] acc_im_q, acc_im_d;
    logic signed [OUT_W-1:0] re_q, re_d;
    logic signed [OUT_W-1:0] im_q, im_d;
    logic                    drop_err_q, drop_err_d;
    logic signed [OUT_W-1:0] tc;

    sm_to_tc #(
        .MAG_W(MAG_W),
        .OUT_W(OUT_W)
    ) u_sm_to_tc (
        .prd(prd_in),
        .tc (tc)
    );

    function automatic logic signed [OUT_W-1:0] scale_sum(input logic signed [OUT_W-1:0] s);
`ifdef CMUL_SCALE_EN
        logic [OUT_W:0] t;
        // One extra bit so +1 cannot overflow before the halving shift
        t = {s[OUT_W-1], s} + (OUT_W+1)'(1);
        return $signed(t[OUT_W:1]);
`else
        return s;
`endif
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        re_d       = re_q;
        im_d       = im_q;
        drop_err_d = drop_err_q;

        if (flush) begin
            state_d  = COLLECT;
            idx_d    = IDX_RR;
            acc_re_d = '0;
            acc_im_d = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (prd_rdy) begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            IDX_RR:  acc_re_d = tc;
                            IDX_II:  acc_re_d = acc_re_q - tc;
                            IDX_RI:  acc_im_d = tc;
                            default: begin
                                acc_im_d = acc_im_q + tc;
                                re_d     = scale_sum(acc_re_q);
                                im_d     = scale_sum(acc_im_q + tc);
                                state_d  = HOLD;
                            end
                        endcase
                    end
                end
                default: begin
                    if (prd_rdy) begin
                        drop_err_d = 1'b1;
                    end
                    if (out_ready) begin
                        state_d = COLLECT;
                        idx_d   = IDX_RR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            idx_q      <= IDX_RR;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            re_q       <= '0;
            im_q       <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            re_q       <= re_d;
            im_q       <= im_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign re_out    = re_q;
    assign im_out    = im_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_fft_cmul_combine.sv
// Self-checking bench for fft_cmul_combine: directed scenarios plus randomized transactions
// compared against an arithmetic reference model.
module tb_fft_cmul_combine;

    localparam int MAG_W = 16;
    localparam int OUT_W = MAG_W + 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic [MAG_W:0]          prd_in = '0;
    logic                    prd_rdy = 1'b0;
    logic                    in_ready;
    logic signed [OUT_W-1:0] re_out;
    logic signed [OUT_W-1:0] im_out;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    drop_err;

    int errors = 0;
    int checks = 0;

    fft_cmul_combine #(.MAG_W(MAG_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .prd_in(prd_in), .prd_rdy(prd_rdy),
        .in_ready(in_ready), .re_out(re_out), .im_out(im_out), .out_valid(out_valid),
        .out_ready(out_ready), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the signed values
    function automatic int tc_of(input bit s, input int m);
        return s ? -m : m;
    endfunction

    function automatic int scl(input int v);
`ifdef CMUL_SCALE_EN
        int t;
        t = v + 1;
        return (t >= 0) ? t / 2 : -((1 - t) / 2);
`else
        return v;
`endif
    endfunction

    task automatic send(input bit s, input int m);
        prd_in  = {s, m[MAG_W-1:0]};
        prd_rdy = 1'b1;
        @(negedge clk);
        prd_rdy = 1'b0;
    endtask

    task automatic run_txn(input string tag, input bit s0, input int m0, input bit s1, input int m1,
                           input bit s2, input int m2, input bit s3, input int m3,
                           input int gap, input int hold, input bit poke);
        int exp_re, exp_im;
        exp_re = scl(tc_of(s0, m0) - tc_of(s1, m1));
        exp_im = scl(tc_of(s2, m2) + tc_of(s3, m3));
        out_ready = (hold == 0);
        send(s0, m0);
        repeat (gap) @(negedge clk);
        send(s1, m1);
        repeat (gap) @(negedge clk);
        send(s2, m2);
        repeat (gap) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid got=%0b exp=0", tag, out_valid);
        end
        send(s3, m3);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_valid got=%0b/%0b exp=1/0", tag, out_valid, in_ready);
        end
        checks++;
        if (re_out !== OUT_W'(exp_re) || im_out !== OUT_W'(exp_im)) begin
            errors++;
            $display("FAIL %s result got re=%0d im=%0d exp re=%0d im=%0d", tag, re_out, im_out, exp_re, exp_im);
        end
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin
                prd_in  = {1'b0, 16'd777};
                prd_rdy = 1'b1;
            end
            @(negedge clk);
            prd_rdy = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || re_out !== OUT_W'(exp_re) || im_out !== OUT_W'(exp_im)) begin
                errors++;
                $display("FAIL %s hold_stable got v=%0b re=%0d im=%0d exp v=1 re=%0d im=%0d",
                         tag, out_valid, re_out, im_out, exp_re, exp_im);
            end
        end
        if (poke) begin
            checks++;
            if (drop_err !== 1'b1) begin
                errors++;
                $display("FAIL %s drop_err got=%0b exp=1", tag, drop_err);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release got v=%0b rdy=%0b exp v=0 rdy=1", tag, out_valid, in_ready);
        end
        $display("txn %s re=%0d im=%0d exp re=%0d im=%0d hold=%0d", tag, re_out, im_out, exp_re, exp_im, hold);
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (re_out !== '0 || im_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL %s idle got re=%0d im=%0d v=%0b rdy=%0b drop=%0b exp 0 0 0 1 0",
                     tag, re_out, im_out, out_valid, in_ready, drop_err);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_idle("reset_active");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_basic();
        run_txn("basic", 0, 300, 1, 200, 0, 50, 0, 70, 0, 0, 0);
    endtask

    task automatic test_extremes();
        run_txn("extremes", 0, 65535, 1, 65535, 1, 65535, 1, 65535, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 0, 1234, 0, 34, 1, 9, 0, 4000, 0, 5, 1);
        run_txn("after_bp", 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        send(0, 11);
        send(1, 22);
        send(0, 33);
        #2 rst_n = 1'b0;
        #1 check_idle("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_release");
        run_txn("neg_zero", 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        send(0, 100);
        send(0, 7);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_txn("flush_partial", 0, 10, 0, 3, 1, 4, 0, 4, 0, 0, 0);
        prd_in  = {1'b0, 16'd999};
        prd_rdy = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        prd_rdy = 1'b0;
        flush   = 1'b0;
        run_txn("flush_coincident", 0, 5, 1, 6, 0, 7, 1, 8, 0, 0, 0);
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_coincident drop_err got=%0b exp=0", drop_err);
        end
        send(0, 1);
        send(0, 2);
        send(0, 3);
        send(0, 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_pending got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
        end
        run_txn("after_flush", 1, 40, 0, 2, 0, 15, 1, 16, 1, 0, 0);
    endtask

    task automatic test_scale();
        run_txn("scale_pos_neg", 0, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        run_txn("scale_basic", 0, 300, 1, 200, 0, 50, 0, 70, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            run_txn($sformatf("rand%0d", t),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_flush();
        test_scale();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
